// File: rtl/alu_control_seq_if.sv
// Handshake/bus bundle between the main control unit (master) and
// the registered ALU control sequencer (slave).
interface alu_control_seq_if #(
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              flush;
    logic              out_valid;
    logic [CTRL_W-1:0] ctrl_out;
    logic              illegal;
    logic              md_start;
    logic              md_op;
    logic              busy;

    modport master (
        output in_valid, alu_op, funct, flush,
        input  in_ready, out_valid, ctrl_out, illegal, md_start, md_op, busy
    );

    modport slave (
        input  in_valid, alu_op, funct, flush,
        output in_ready, out_valid, ctrl_out, illegal, md_start, md_op, busy
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with optional multi-cycle mult/div sequencing.
// Define ALU_CTRL_MULDIV_EN to decode mult/div and enable the MD_BUSY sequencer.
module alu_control_seq #(
    parameter int         CTRL_W       = 4,
    parameter int         MULDIV_LAT   = 8,
    parameter logic [3:0] ILLEGAL_CODE = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_control_seq_if.slave bus
);
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    logic [3:0]        dec_code;
    logic              dec_illegal;
    logic              accept;
    logic              out_valid_d, out_valid_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic              illegal_d, illegal_q;

`ifdef ALU_CTRL_MULDIV_EN
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam int         CNT_W  = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

    typedef enum logic {IDLE, MD_BUSY} state_e;

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             md_start_d, md_start_q;
    logic             md_op_d, md_op_q;
    logic             dec_md;

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q == MD_BUSY);
    assign bus.md_start = md_start_q;
    assign bus.md_op    = md_op_q;
`else
    assign bus.in_ready = 1'b1;
    assign bus.busy     = 1'b0;
    assign bus.md_start = 1'b0;
    assign bus.md_op    = 1'b0;
`endif

    assign accept        = bus.in_valid & bus.in_ready & ~bus.flush;
    assign bus.out_valid = out_valid_q;
    assign bus.ctrl_out  = ctrl_q;
    assign bus.illegal   = illegal_q;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        dec_code    = ILLEGAL_CODE;
        dec_illegal = 1'b1;
`ifdef ALU_CTRL_MULDIV_EN
        dec_md      = 1'b0;
`endif
        case (bus.alu_op)
            2'b00: begin dec_code = 4'b0010; dec_illegal = 1'b0; end
            2'b01: begin dec_code = 4'b0011; dec_illegal = 1'b0; end
            2'b10: begin
                case (bus.funct)
                    F_ADD:  begin dec_code = 4'b0010; dec_illegal = 1'b0; end
                    F_SUB:  begin dec_code = 4'b0011; dec_illegal = 1'b0; end
                    F_AND:  begin dec_code = 4'b0000; dec_illegal = 1'b0; end
                    F_OR:   begin dec_code = 4'b0001; dec_illegal = 1'b0; end
                    F_SLT:  begin dec_code = 4'b0111; dec_illegal = 1'b0; end
`ifdef ALU_CTRL_MULDIV_EN
                    F_MULT: begin dec_code = 4'b0100; dec_illegal = 1'b0; dec_md = 1'b1; end
                    F_DIV:  begin dec_code = 4'b0101; dec_illegal = 1'b0; dec_md = 1'b1; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        out_valid_d = 1'b0;
        ctrl_d      = ctrl_q;
        illegal_d   = illegal_q;
`ifdef ALU_CTRL_MULDIV_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_start_d  = 1'b0;
        md_op_d     = md_op_q;
        case (state_q)
            IDLE: begin
                if (accept && dec_md) begin
                    state_d    = MD_BUSY;
                    cnt_d      = CNT_W'(MULDIV_LAT - 1);
                    md_op_d    = (bus.funct == F_DIV);
                    md_start_d = 1'b1;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    ctrl_d      = CTRL_W'(dec_code);
                    illegal_d   = dec_illegal;
                end
            end
            MD_BUSY: begin
                // Flush wins over completion: the result of an aborted op is never published.
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    ctrl_d      = CTRL_W'(md_op_q ? 4'b0101 : 4'b0100);
                    illegal_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`else
        if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = CTRL_W'(dec_code);
            illegal_d   = dec_illegal;
        end
`endif
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
            state_q     <= IDLE;
            cnt_q       <= '0;
            md_start_q  <= 1'b0;
            md_op_q     <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            illegal_q   <= illegal_d;
`ifdef ALU_CTRL_MULDIV_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_start_q  <= md_start_d;
            md_op_q     <= md_op_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed steps plus random traffic,
// compared against a timestamp-based reference model of the decode/sequencing rules.
module tb_alu_control_seq;
    localparam int CTRL_W = 4;
    localparam int LAT    = 8;
`ifdef ALU_CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] f;
        logic [3:0] c;
        logic       md;
    } row_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_control_seq_if #(.CTRL_W(CTRL_W)) bus ();

    alu_control_seq #(
        .CTRL_W      (CTRL_W),
        .MULDIV_LAT  (LAT),
        .ILLEGAL_CODE(4'b1111)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: held outputs plus the edge index at which a mult/div finishes.
    row_t       rtab [7];
    int         n       = 0;
    int         done_at = -1;
    logic [3:0] pend    = 4'h0;
    logic [3:0] exp_ctrl;
    logic       exp_ill, exp_ov, exp_ms, exp_mdop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                       output logic [3:0] c, output logic ill, output logic md);
        c = 4'hF; ill = 1'b1; md = 1'b0;
        if (op == 2'b00) begin c = 4'h2; ill = 1'b0; end
        else if (op == 2'b01) begin c = 4'h3; ill = 1'b0; end
        else if (op == 2'b10) begin
            foreach (rtab[i])
                if (rtab[i].f == f && (!rtab[i].md || MD_EN)) begin
                    c = rtab[i].c; ill = 1'b0; md = rtab[i].md;
                end
        end
    endfunction

    task automatic cycle(input logic v, input logic [1:0] op, input logic [5:0] f, input logic fl);
        logic [3:0] c;
        logic       ill, md, busy_m;
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.funct    = f;
        bus.flush    = fl;
        #1;
        busy_m = (done_at >= n);
        check("in_ready", bus.in_ready, !busy_m);
        exp_ov = 1'b0;
        exp_ms = 1'b0;
        if (busy_m) begin
            if (fl) done_at = -1;
            else if (n == done_at) begin
                exp_ov = 1'b1; exp_ctrl = pend; exp_ill = 1'b0; done_at = -1;
            end
        end else if (v && !fl) begin
            ref_decode(op, f, c, ill, md);
            if (md) begin
                done_at = n + LAT; pend = c; exp_ms = 1'b1; exp_mdop = (c == 4'h5);
            end else begin
                exp_ov = 1'b1; exp_ctrl = c; exp_ill = ill;
            end
        end
        @(posedge clk);
        n++;
        #1;
        check("out_valid", bus.out_valid, exp_ov);
        check("ctrl_out",  bus.ctrl_out,  exp_ctrl);
        check("illegal",   bus.illegal,   exp_ill);
        check("md_start",  bus.md_start,  exp_ms);
        check("md_op",     bus.md_op,     exp_mdop);
        check("busy",      bus.busy,      done_at >= n);
    endtask

    task automatic drain();
        for (int k = 0; k < LAT + 2 && done_at >= n; k++) cycle(1'b0, 2'b00, 6'd0, 1'b0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_ctrl_out",  bus.ctrl_out,  4'h0);
        check("rst_illegal",   bus.illegal,   1'b0);
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_md_start",  bus.md_start,  1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        exp_ctrl = 4'h0; exp_ill = 1'b0; exp_ov = 1'b0; exp_ms = 1'b0; exp_mdop = 1'b0;
        done_at = -1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [5:0] sweep_f [8];
        int         lat;

        rtab[0] = '{6'b100000, 4'b0010, 1'b0};
        rtab[1] = '{6'b100010, 4'b0011, 1'b0};
        rtab[2] = '{6'b100100, 4'b0000, 1'b0};
        rtab[3] = '{6'b100101, 4'b0001, 1'b0};
        rtab[4] = '{6'b101010, 4'b0111, 1'b0};
        rtab[5] = '{6'b011000, 4'b0100, 1'b1};
        rtab[6] = '{6'b011010, 4'b0101, 1'b1};
        foreach (rtab[i]) sweep_f[i] = rtab[i].f;
        sweep_f[7] = 6'b000111;

        bus.in_valid = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'd0;
        bus.flush    = 1'b0;

        // Power-on reset, then a mid-cycle reset after some traffic.
        do_reset();
        cycle(1'b1, 2'b10, 6'b101010, 1'b0);
        cycle(1'b1, 2'b11, 6'b000000, 1'b0);
        do_reset();

        // Decode table sweep.
        for (int op = 0; op < 4; op++)
            for (int i = 0; i < 8; i++) begin
                cycle(1'b1, 2'(op), sweep_f[i], 1'b0);
                drain();
            end
        cycle(1'b1, 2'b10, 6'b000111, 1'b0);
        check("unknown_code", bus.ctrl_out, 4'hF);
        check("unknown_flag", bus.illegal, 1'b1);

        // Back-to-back single-cycle ops.
        cycle(1'b1, 2'b10, 6'b100000, 1'b0);
        check("b2b_add", {bus.out_valid, bus.ctrl_out}, 5'h12);
        cycle(1'b1, 2'b10, 6'b100010, 1'b0);
        check("b2b_sub", {bus.out_valid, bus.ctrl_out}, 5'h13);
        cycle(1'b1, 2'b10, 6'b100100, 1'b0);
        check("b2b_and", {bus.out_valid, bus.ctrl_out}, 5'h10);
        cycle(1'b1, 2'b10, 6'b100101, 1'b0);
        check("b2b_or",  {bus.out_valid, bus.ctrl_out}, 5'h11);

        // Mult with a held add behind it; latency counted in edges after the accept edge.
        cycle(1'b1, 2'b10, 6'b011000, 1'b0);
        lat = bus.out_valid ? 0 : -1;
        for (int k = 1; k <= LAT + 1; k++) begin
            cycle(1'b1, 2'b10, 6'b100000, 1'b0);
            if (lat < 0 && bus.out_valid) lat = k;
        end
        check("md_latency", lat, MD_EN ? LAT : 0);
        check("held_add", {bus.out_valid, bus.ctrl_out}, 5'h12);

        // Div aborted by flush in its third cycle; no pulse may follow.
        cycle(1'b1, 2'b10, 6'b011010, 1'b0);
        cycle(1'b0, 2'b00, 6'd0, 1'b0);
        cycle(1'b0, 2'b00, 6'd0, 1'b0);
        cycle(1'b0, 2'b00, 6'd0, 1'b1);
        check("flush_busy", bus.busy, 1'b0);
        for (int k = 0; k < LAT + 2; k++) cycle(1'b0, 2'b00, 6'd0, 1'b0);

        // Flush in idle suppresses a simultaneous accept.
        cycle(1'b1, 2'b01, 6'd0, 1'b1);
        check("flush_idle", bus.out_valid, 1'b0);

        // Reset in the middle of a mult: no pulse after release.
        cycle(1'b1, 2'b10, 6'b011000, 1'b0);
        cycle(1'b0, 2'b00, 6'd0, 1'b0);
        do_reset();
        for (int k = 0; k < LAT + 2; k++) cycle(1'b0, 2'b00, 6'd0, 1'b0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            int   idx;
            logic [5:0] f;
            idx = int'($urandom_range(0, 8));
            f   = (idx < 8) ? sweep_f[idx] : 6'($urandom);
            cycle(($urandom_range(0, 3) != 0), 2'($urandom), f, ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
